aes128_cipher_loader: RTL and testbench



---
 rtl/aes128_cipher_loader.sv | 165 ++++++++++++++++
 tb/tb_aes128_cipher_loader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_cipher_loader.sv
// Assembles a 128-bit key and plaintext from a 32-bit valid/ready bus and launches the AES core.
// Defining AES_LOADER_TIMEOUT_EN adds a sticky watchdog on the wait-for-completion state.
module aes128_cipher_loader #(
    parameter int unsigned WAIT_MIN       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_is_key,
    output logic [127:0] cipher_key,
    output logic [127:0] plain_text,
    output logic         cipher_en,
    input  logic         cipher_ready,
    output logic         key_valid,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);

    if (WAIT_MIN < 1) begin : g_bad_wait_min
        $error("WAIT_MIN must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam int unsigned GuardW = $clog2(WAIT_MIN + 1);
    localparam logic [GuardW-1:0] GuardLast = GuardW'(WAIT_MIN - 1);

    typedef enum logic [1:0] {StIdle, StPend, StLaunch, StWait} state_e;

    state_e            state;
    logic [1:0]        key_cnt;
    logic [1:0]        pt_cnt;
    // Only the first three words need staging; the fourth commits straight from the bus.
    logic [95:0]       key_stage;
    logic [95:0]       pt_stage;
    logic [GuardW-1:0] guard;
    logic              guard_done;
    logic              key_acc;
    logic              pt_acc;
    logic              key_last;
    logic              pt_last;

`ifdef AES_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    logic [TmoW-1:0] tmo_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                StIdle:  in_ready = 1'b1;
                StPend:  in_ready = in_is_key;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign key_acc    = in_valid && in_ready && in_is_key;
    assign pt_acc     = in_valid && in_ready && !in_is_key;
    assign key_last   = key_acc && (key_cnt == 2'd3);
    assign pt_last    = pt_acc && (pt_cnt == 2'd3);
    assign guard_done = (guard >= GuardLast);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            key_cnt    <= 2'd0;
            pt_cnt     <= 2'd0;
            key_stage  <= '0;
            pt_stage   <= '0;
            cipher_key <= '0;
            plain_text <= '0;
            key_valid  <= 1'b0;
            cipher_en  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            guard      <= '0;
`ifdef AES_LOADER_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            cipher_en <= 1'b0;
            done      <= 1'b0;

            if (key_acc) begin
                key_cnt <= key_cnt + 2'd1;
                if (key_last) begin
                    cipher_key <= {key_stage, in_data};
                    key_valid  <= 1'b1;
                end else begin
                    key_stage <= {key_stage[63:0], in_data};
                    key_valid <= 1'b0;
                end
            end

            if (pt_acc) begin
                pt_cnt <= pt_cnt + 2'd1;
                if (pt_last) begin
                    plain_text <= {pt_stage, in_data};
                end else begin
                    pt_stage <= {pt_stage[63:0], in_data};
                end
            end

            unique case (state)
                StIdle: begin
                    if (pt_last) begin
                        if (key_valid) begin
                            state     <= StLaunch;
                            cipher_en <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= StPend;
                        end
                    end
                end
                StPend: begin
                    if (key_last) begin
                        state     <= StLaunch;
                        cipher_en <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StLaunch: begin
                    state <= StWait;
                    guard <= '0;
`ifdef AES_LOADER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                StWait: begin
                    if (!guard_done) begin
                        guard <= guard + GuardW'(1);
                    end
                    // Completion wins over a timeout sampled at the same edge.
                    if (guard_done && cipher_ready) begin
                        state <= StIdle;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
`ifdef AES_LOADER_TIMEOUT_EN
                    else if (tmo_cnt == TmoLast) begin
                        state       <= StIdle;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoW'(1);
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_cipher_loader.sv
// Self-checking bench for aes128_cipher_loader: directed and randomized blocks against a
// cycle-level reference of launch/done timing and word assembly.
module tb_aes128_cipher_loader;

    localparam int unsigned WMIN = 2;
    localparam int unsigned TMO  = 8;

    logic         clk_sys = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_is_key;
    logic [127:0] cipher_key;
    logic [127:0] plain_text;
    logic         cipher_en;
    logic         cipher_ready;
    logic         key_valid;
    logic         busy;
    logic         done;
    logic         timeout_err;

    aes128_cipher_loader #(
        .WAIT_MIN       (WMIN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_is_key    (in_is_key),
        .cipher_key   (cipher_key),
        .plain_text   (plain_text),
        .cipher_en    (cipher_en),
        .cipher_ready (cipher_ready),
        .key_valid    (key_valid),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [127:0] cap_key = '0;
    logic [127:0] cap_pt = '0;
    logic         cap_kv = 1'b0;
    logic [127:0] cur_key = '0;

    // Edge counter and event capture, sampled mid-cycle.
    always @(posedge clk_sys) cyc <= cyc + 1;
    always @(negedge clk_sys) begin
        if (cipher_en) begin
            en_cnt  <= en_cnt + 1;
            en_cyc  <= cyc;
            cap_key <= cipher_key;
            cap_pt  <= plain_text;
            cap_kv  <= key_valid;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called and returns at negedge+1; e is the edge at which the word was accepted.
    task automatic send(input logic k, input logic [31:0] d, output int e);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_is_key = k;
        in_data   = d;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        if (n >= 100) check("send_accept", in_ready, 1'b1);
        @(posedge clk_sys);
        #1;
        e = cyc;
        in_valid = 1'b0;
        @(negedge clk_sys);
        #1;
    endtask

    task automatic wait_launch(input int pe);
        int n;
        n = 0;
        while (en_cnt == pe && n < 100) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check("launch_count", en_cnt, pe + 1);
    endtask

    task automatic finish_block(input int e_exp, input logic [127:0] k, input logic [127:0] p,
                                input int lat, input logic stale, input int pe, input int pd);
        int r;
        int d_exp;
        int n;
        wait_launch(pe);
        check("launch_edge", en_cyc, e_exp);
        check("launch_plain", cap_pt, p);
        check("launch_key", cap_key, k);
        check("launch_key_valid", cap_kv, 1'b1);
        r = 0;
        if (!stale) begin
            repeat (lat) begin
                @(negedge clk_sys);
                #1;
            end
            cipher_ready = 1'b1;
            r = cyc;
        end
        // Ready is ignored until WAIT_MIN+1 edges after launch; done follows the sampling edge.
        d_exp = e_exp + WMIN + 1;
        if (!stale && r + 1 > d_exp) d_exp = r + 1;
        n = 0;
        while (done_cnt == pd && n < 200) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check("done_count", done_cnt, pd + 1);
        check("done_edge", done_cyc, d_exp);
        check("hold_key", cipher_key, k);
        check("hold_plain", plain_text, p);
        check("ready_after_done", in_ready, 1'b1);
        check("busy_after_done", busy, 1'b0);
        check("key_valid_after_done", key_valid, 1'b1);
        if (!stale) cipher_ready = 1'b0;
        @(negedge clk_sys);
        #1;
        check("single_done", done_cnt, pd + 1);
        check("single_launch", en_cnt, pe + 1);
    endtask

    // mode 0: key words first, 1: random interleave, 2: strict alternation
    task automatic run_block(input logic new_key, input logic [127:0] k, input logic [127:0] p,
                             input int mode, input int lat, input logic stale);
        int ki;
        int pi;
        int nk;
        int e;
        int pe;
        int pd;
        logic pick_key;
        ki = 0;
        pi = 0;
        nk = new_key ? 4 : 0;
        e  = 0;
        pe = en_cnt;
        pd = done_cnt;
        while (ki < nk || pi < 4) begin
            if (ki >= nk) pick_key = 1'b0;
            else if (pi >= 4) pick_key = 1'b1;
            else if (mode == 0) pick_key = 1'b1;
            else if (mode == 2) pick_key = (ki <= pi);
            else pick_key = 1'($urandom_range(0, 1));
            if (pick_key) begin
                send(1'b1, k[127-32*ki -: 32], e);
                ki++;
            end else begin
                send(1'b0, p[127-32*pi -: 32], e);
                pi++;
            end
        end
        if (new_key) cur_key = k;
        // Launch coincides with whichever stream completes last.
        finish_block(e, cur_key, p, lat, stale, pe, pd);
    endtask

    initial begin
        logic [127:0] k;
        logic [127:0] p;
        int e;
        int pe;
        int pd;
        int n;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_is_key    = 1'b0;
        in_data      = '0;
        cipher_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_key", cipher_key, 128'h0);
        check("rst_plain", plain_text, 128'h0);
        check("rst_cipher_en", cipher_en, 1'b0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1'b1);

        // Single block with the reference vectors.
        run_block(1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff, 0, 2, 1'b0);
        // Key reuse.
        run_block(1'b0, '0, rand128(), 1, $urandom_range(0, 5), 1'b0);
        // Alternating key and plaintext words.
        run_block(1'b1, rand128(), rand128(), 2, $urandom_range(0, 5), 1'b0);
        // Stale ready held high.
        cipher_ready = 1'b1;
        run_block(1'b0, '0, rand128(), 1, 0, 1'b1);
        cipher_ready = 1'b0;

        // A new key word drops key_valid but keeps the old key; plaintext then stalls in PEND.
        pe = en_cnt;
        pd = done_cnt;
        k  = rand128();
        p  = rand128();
        send(1'b1, k[127:96], e);
        check("key_valid_drop", key_valid, 1'b0);
        check("key_hold_old", cipher_key, cur_key);
        for (int i = 0; i < 4; i++) send(1'b0, p[127-32*i -: 32], e);
        in_valid  = 1'b1;
        in_is_key = 1'b0;
        in_data   = 32'hdeadbeef;
        #1;
        check("pend_plain_stall", in_ready, 1'b0);
        in_is_key = 1'b1;
        #1;
        check("pend_key_ready", in_ready, 1'b1);
        in_valid  = 1'b0;
        in_is_key = 1'b0;
        @(negedge clk_sys);
        #1;
        check("pend_no_launch", en_cnt, pe);
        for (int i = 1; i < 4; i++) send(1'b1, k[127-32*i -: 32], e);
        cur_key = k;
        finish_block(e, k, p, 1, 1'b0, pe, pd);

        for (int b = 0; b < 6; b++) begin
            run_block(1'($urandom_range(0, 1)), rand128(), rand128(), 1,
                      $urandom_range(0, 6), 1'b0);
        end

        pe = en_cnt;
        pd = done_cnt;
        p  = rand128();
        for (int i = 0; i < 4; i++) send(1'b0, p[127-32*i -: 32], e);
        wait_launch(pe);
`ifdef AES_LOADER_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check("timeout_flag", timeout_err, 1'b1);
        check("timeout_edge", cyc, e + 1 + TMO);
        check("timeout_no_done", done_cnt, pd);
        check("timeout_key_valid", key_valid, 1'b1);
        check("timeout_idle", in_ready, 1'b1);
        repeat (3) @(negedge clk_sys);
        #1;
        check("timeout_sticky", timeout_err, 1'b1);
        pe = en_cnt;
        for (int i = 0; i < 4; i++) send(1'b0, p[127-32*i -: 32], e);
        wait_launch(pe);
`else
        n = 0;
        repeat (20) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check("wait_holds_busy", busy, 1'b1);
        check("wait_no_done", done_cnt, pd);
        check("wait_no_timeout", timeout_err, 1'b0);
        check("wait_in_ready", in_ready, 1'b0);
`endif
        // Asynchronous reset while waiting on the core.
        @(negedge clk_sys);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_key", cipher_key, 128'h0);
        check("mid_rst_plain", plain_text, 128'h0);
        check("mid_rst_key_valid", key_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cipher_en", cipher_en, 1'b0);
        check("mid_rst_timeout", timeout_err, 1'b0);
        @(negedge clk_sys);
        rst = 1'b0;
        pe  = en_cnt;
        cipher_ready = 1'b1;
        repeat (10) @(negedge clk_sys);
        #1;
        check("post_rst_no_launch", en_cnt, pe);
        check("post_rst_idle", in_ready, 1'b1);
        check("post_rst_done", done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
